bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_serial_adder_if.sv | 19 +
 rtl/bcd_adder.sv | 26 ++
 rtl/bcd_serial_adder.sv | 134 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle between a requester and the serial BCD adder.
interface bcd_serial_adder_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) ();

    logic                    start;
    bcd_digit_t [DIGITS-1:0] a;
    bcd_digit_t [DIGITS-1:0] b;
    logic                    ready;
    logic                    done;
    bcd_digit_t [DIGITS:0]   sum;
    logic                    err;

    modport master (output start, a, b, input ready, done, sum, err);
    modport slave  (input start, a, b, output ready, done, sum, err);

endinterface

// File: rtl/bcd_adder.sv
// Single-digit BCD adder: a + b + cin -> decimal ones digit and carry.
module bcd_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum_c,
    output logic       cout_c
);

    logic [4:0] raw;

    // Binary add, then +6 correction when the result leaves the decimal range.
    always_comb begin
        raw = 5'(a) + 5'(b) + 5'(cin);
        if (raw > 5'(BCD_MAX)) begin
            sum_c  = 4'(raw + 5'd6);
            cout_c = 1'b1;
        end else begin
            sum_c  = raw[3:0];
            cout_c = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one shared digit adder, one digit per cycle.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  bcd_digit_t [DIGITS-1:0] a,
    input  bcd_digit_t [DIGITS-1:0] b,
    output logic                    ready,
    output logic                    done,
    output bcd_digit_t [DIGITS:0]   sum,
    output logic                    err
);

    localparam int unsigned IDX_W = $clog2(DIGITS + 1);

    state_t                  state_q, state_d;
    bcd_digit_t [DIGITS-1:0] a_q, a_d;
    bcd_digit_t [DIGITS-1:0] b_q, b_d;
    bcd_digit_t [DIGITS:0]   sum_q, sum_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;

    bcd_digit_t              dig_a, dig_b, add_sum;
    logic                    add_cout;

    // Digit-indexed operand muxes feeding the shared adder.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                dig_a = a_q[k];
                dig_b = b_q[k];
            end
        end
    end

    bcd_adder u_bcd_adder (
        .a      (dig_a),
        .b      (dig_b),
        .cin    (carry_q),
        .sum_c  (add_sum),
        .cout_c (add_cout)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int k = 0; k < int'(DIGITS); k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k] = add_sum;
                    end
                end
                carry_d = add_cout;
                if ((dig_a > BCD_MAX) || (dig_b > BCD_MAX)) begin
                    err_d = 1'b1;
                end
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    sum_d[DIGITS] = {3'b000, add_cout};
                    state_d       = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS = 4) against a decimal model.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (bus.start),
        .a     (bus.a),
        .b     (bus.b),
        .ready (bus.ready),
        .done  (bus.done),
        .sum   (bus.sum),
        .err   (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(v[i*4 +: 4]);
        return n;
    endfunction

    function automatic logic [19:0] int2bcd(input int n);
        logic [19:0] r;
        int          m;
        m = n;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [15:0] v);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // One complete operation with cycle-exact checks; optional disturbance while busy.
    task automatic do_add(input logic [15:0] av, input logic [15:0] bv,
                          input bit disturb, input logic [15:0] da, input logic [15:0] db);
        logic [19:0] exp_sum;
        bit          exp_err;
        exp_err = has_bad(av) || has_bad(bv);
        exp_sum = int2bcd(bcd2int(av) + bcd2int(bv));
        @(negedge clk);
        chk("ready_idle", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk); #1;
        bus.start = disturb;
        if (disturb) begin
            bus.a = da;
            bus.b = db;
        end
        chk("accept_ready", 32'(bus.ready), 32'd0);
        chk("accept_done", 32'(bus.done), 32'd0);
        chk("accept_sum_clear", 32'(bus.sum), 32'd0);
        for (int k = 1; k < int'(DIGITS); k++) begin
            @(posedge clk); #1;
            chk("busy_done", 32'(bus.done), 32'd0);
            chk("busy_ready", 32'(bus.ready), 32'd0);
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_ready", 32'(bus.ready), 32'd0);
        chk("done_err", 32'(bus.err), 32'(exp_err));
        if (!exp_err) chk("done_sum", 32'(bus.sum), 32'(exp_sum));
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("after_done", 32'(bus.done), 32'd0);
        chk("after_ready", 32'(bus.ready), 32'd1);
        chk("hold_err", 32'(bus.err), 32'(exp_err));
        if (!exp_err) chk("hold_sum", 32'(bus.sum), 32'(exp_sum));
    endtask

    initial begin
        logic [15:0] ra, rb;
        vectors     = 0;
        miscompares = 0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        reset       = 1'b1;

        // Reset state
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic add and full carry ripple
        do_add(16'h1234, 16'h5678, 1'b0, 16'h0, 16'h0);
        chk("basic_value", 32'(bus.sum), 32'h06912);
        do_add(16'h9999, 16'h0001, 1'b0, 16'h0, 16'h0);
        chk("ripple_value", 32'(bus.sum), 32'h10000);
        do_add(16'h9999, 16'h9999, 1'b0, 16'h0, 16'h0);

        // Busy: start pulses with new operands ignored, then back-to-back start
        do_add(16'h0000, 16'h0000, 1'b1, 16'h1111, 16'h1111);
        chk("busy_ignored_sum", 32'(bus.sum), 32'h00000);
        do_add(16'h1111, 16'h1111, 1'b0, 16'h0, 16'h0);
        chk("b2b_value", 32'(bus.sum), 32'h02222);

        // Reset mid-operation, asynchronous and without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h4321;
        bus.b     = 16'h1111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        do_add(16'h4321, 16'h1111, 1'b0, 16'h0, 16'h0);
        chk("postrst_value", 32'(bus.sum), 32'h05432);

        // Invalid digit, then a clean add clears err
        do_add(16'h12A4, 16'h0001, 1'b0, 16'h0, 16'h0);
        do_add(16'h0005, 16'h0005, 1'b0, 16'h0, 16'h0);
        chk("err_cleared_value", 32'(bus.sum), 32'h00010);

        // Operand change right after acceptance
        do_add(16'h0567, 16'h0432, 1'b0, 16'h0, 16'h0);
        do_add(16'h2468, 16'h1357, 1'b1, 16'h9999, 16'h9999);

        // Randomized operations, some with an out-of-range digit
        for (int n = 0; n < 30; n++) begin
            ra = 16'(int2bcd(int'($urandom_range(0, 9999))));
            rb = 16'(int2bcd(int'($urandom_range(0, 9999))));
            if ($urandom_range(0, 3) == 0) ra[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 5) == 0) rb[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            do_add(ra, rb, n[0], 16'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
